nibble_alu_sequencer: RTL

- Sequences an 8-bit add or subtract through the shared 4-bit carry-lookahead adder: low nibble first, then high nibble.
- Sits directly upstream of the adder and drives its A, B, c_in and en inputs.
- Consumes the adder's Output, c_out and ready outputs, assembles the 8-bit result and the C/Z/N/V flags, and hands them to the accumulator/flag register stage with a start/done handshake.

---
 rtl/nibble_alu_sequencer_if.sv | 20 ++
 rtl/nibble_alu_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_alu_sequencer_if.sv
// Bus between the nibble sequencer and the shared 4-bit carry-lookahead adder.
interface nibble_alu_sequencer_if;
  logic [3:0] add_a;
  logic [3:0] add_b;
  logic       add_cin;
  logic       add_en;
  logic [3:0] add_sum;
  logic       add_cout;
  logic       add_ready;

  modport master (
    output add_a, add_b, add_cin, add_en,
    input  add_sum, add_cout, add_ready
  );

  modport slave (
    input  add_a, add_b, add_cin, add_en,
    output add_sum, add_cout, add_ready
  );
endinterface

// File: rtl/nibble_alu_sequencer.sv
// Runs an 8-bit ADD/ADC/SUB/SBB as two passes through a shared 4-bit adder,
// low nibble first, and reports the result with C/Z/N/V flags and a timeout error.
module nibble_alu_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       flag_n,
  output logic       flag_v,
  output logic       err,
  nibble_alu_sequencer_if.master adder
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LO   = 3'd1,
    S_GAP  = 3'd2,
    S_HI   = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [DATA_W-1:0] a_r, a_d;
  logic [DATA_W-1:0] eb_r, eb_d;
  logic [NIB_W-1:0]  lo_r, lo_d;
  logic              c4_r, c4_d;

  logic              busy_d, done_d, err_d;
  logic [DATA_W-1:0] result_d;
  logic              flag_c_d, flag_z_d, flag_n_d, flag_v_d;
  logic [NIB_W-1:0]  add_a_r, add_a_d;
  logic [NIB_W-1:0]  add_b_r, add_b_d;
  logic              add_cin_r, add_cin_d;
  logic              add_en_r, add_en_d;

  logic              expired_c;
  logic [DATA_W-1:0] sum_c;

  // ready takes priority over an expiring count in the same cycle
  assign expired_c = !adder.add_ready && (cnt == CNT_W'(TIMEOUT));
  assign sum_c     = {adder.add_sum, lo_r};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (start) state_nx = S_LO;
      S_LO: begin
        if (adder.add_ready) state_nx = S_GAP;
        else if (expired_c)  state_nx = S_DONE;
      end
      S_GAP: state_nx = S_HI;
      S_HI: begin
        if (adder.add_ready || expired_c) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values for every registered output and datapath register
  always_comb begin
    cnt_d     = cnt;
    a_d       = a_r;
    eb_d      = eb_r;
    lo_d      = lo_r;
    c4_d      = c4_r;
    busy_d    = busy;
    done_d    = 1'b0;
    err_d     = err;
    result_d  = result;
    flag_c_d  = flag_c;
    flag_z_d  = flag_z;
    flag_n_d  = flag_n;
    flag_v_d  = flag_v;
    add_a_d   = add_a_r;
    add_b_d   = add_b_r;
    add_cin_d = add_cin_r;
    add_en_d  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          a_d       = a;
          eb_d      = op[1] ? ~b : b;
          add_a_d   = a[3:0];
          add_b_d   = op[1] ? ~b[3:0] : b[3:0];
          // ADC/SBB chain the stored carry; SUB seeds +1 for two's complement
          add_cin_d = op[0] ? flag_c : op[1];
          add_en_d  = 1'b1;
          busy_d    = 1'b1;
          cnt_d     = '0;
        end
      end
      S_LO, S_HI: begin
        if (adder.add_ready) begin
          if (state == S_LO) begin
            lo_d = adder.add_sum;
            c4_d = adder.add_cout;
          end else begin
            result_d = sum_c;
            flag_c_d = adder.add_cout;
            flag_z_d = (sum_c == '0);
            flag_n_d = sum_c[7];
            flag_v_d = (a_r[7] == eb_r[7]) && (sum_c[7] != a_r[7]);
            err_d    = 1'b0;
            done_d   = 1'b1;
            busy_d   = 1'b0;
          end
        end else if (expired_c) begin
          err_d  = 1'b1;
          done_d = 1'b1;
          busy_d = 1'b0;
        end else begin
          cnt_d    = cnt + CNT_W'(1);
          add_en_d = 1'b1;
        end
      end
      S_GAP: begin
        add_a_d   = a_r[7:4];
        add_b_d   = eb_r[7:4];
        add_cin_d = c4_r;
        add_en_d  = 1'b1;
        cnt_d     = '0;
      end
      S_DONE: ;
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      a_r       <= '0;
      eb_r      <= '0;
      lo_r      <= '0;
      c4_r      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      flag_c    <= 1'b0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_v    <= 1'b0;
      add_a_r   <= '0;
      add_b_r   <= '0;
      add_cin_r <= 1'b0;
      add_en_r  <= 1'b0;
    end else begin
      cnt       <= cnt_d;
      a_r       <= a_d;
      eb_r      <= eb_d;
      lo_r      <= lo_d;
      c4_r      <= c4_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      result    <= result_d;
      flag_c    <= flag_c_d;
      flag_z    <= flag_z_d;
      flag_n    <= flag_n_d;
      flag_v    <= flag_v_d;
      add_a_r   <= add_a_d;
      add_b_r   <= add_b_d;
      add_cin_r <= add_cin_d;
      add_en_r  <= add_en_d;
    end
  end

  assign adder.add_a   = add_a_r;
  assign adder.add_b   = add_b_r;
  assign adder.add_cin = add_cin_r;
  assign adder.add_en  = add_en_r;

endmodule
